// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_port_arbiter: transfer width codes, FSM state
// encoding and the beat-count helper.
package mem_arb_pkg;

   localparam logic [2:0] WIDTH_B = 3'd0;
   localparam logic [2:0] WIDTH_H = 3'd1;
   localparam logic [2:0] WIDTH_W = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Codes 3..7 are reserved and behave as a word.
   function automatic logic [2:0] beats(input logic [2:0] width);
      case (width)
         WIDTH_B: beats = 3'd1;
         WIDTH_H: beats = 3'd2;
         WIDTH_W: beats = 3'd4;
         default: beats = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer, and the
// pointer moves to winner+1 (mod NCH) whenever a grant is taken.
module rr_arbiter #(
   parameter int NCH = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] req_i,
   input  logic           adv_i,
   output logic [NCH-1:0] gnt_o
);

   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int SW = PW + 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] win;
   logic [SW-1:0] slot;
   logic          found;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      gnt_o = '0;
      win   = '0;
      slot  = '0;
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         slot = {1'b0, ptr_q} + SW'(i);
         if (slot >= SW'(NCH)) slot = slot - SW'(NCH);
         if (!found && req_i[slot[PW-1:0]]) begin
            gnt_o[slot[PW-1:0]] = 1'b1;
            win                 = slot[PW-1:0];
            found               = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (adv_i && found) begin
         ptr_q <= (win == PW'(NCH - 1)) ? '0 : win + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter and byte-serial sequencer for the 8-bit RAM/IO port.
// Define MEMARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NCH = 3,
   parameter int AW  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic [NCH-1:0]  req,
   input  logic [NCH-1:0]  we,
   input  logic [NCH*AW-1:0] addr,
   input  logic [NCH*3-1:0]  width,
   input  logic [NCH*32-1:0] wdata,
   output logic [31:0]     rdata,
   output logic [NCH-1:0]  done,
   output logic [NCH-1:0]  busy,
   input  logic [7:0]      mem_din,
   output logic [7:0]      mem_dout,
   output logic [AW-1:0]   mem_a,
   output logic            mem_wr
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   state_e         st_q;
   logic           we_q;
   logic [AW-1:0]  addr_q;
   logic [2:0]     nbeat_q;
   logic [31:0]    wdata_q;
   logic [2:0]     issue_q;
   logic [2:0]     cap_q;
   logic           rd_pend_q;
   logic           cap_pend_q;
   logic           stall_q;
   logic [31:0]    buf_q;
   logic [31:0]    rdata_q;
   logic [NCH-1:0] done_q;
   logic [NCH-1:0] busy_q;
   logic [AW-1:0]  mem_a_q;
   logic [7:0]     mem_dout_q;
   logic           mem_wr_q;

   logic [NCH-1:0] req_eff;
   logic [NCH-1:0] gnt_oh;
   logic [IW-1:0]  gnt_idx;
   logic           we_sel;
   logic [AW-1:0]  addr_sel;
   logic [2:0]     width_sel;
   logic [31:0]    wdata_sel;
   logic [31:0]    rd_merge;

   assign req_eff = req & ~done_q;

`ifdef MEMARB_RR_EN
   rr_arbiter #(
      .NCH (NCH)
   ) u_rr_arbiter (
      .clk   (clk),
      .rst_n (rst),
      .req_i (req_eff),
      .adv_i ((st_q == ST_IDLE) && rdy),
      .gnt_o (gnt_oh)
   );
`else
   always_comb begin
      gnt_oh = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (req_eff[i]) begin
            gnt_oh    = '0;
            gnt_oh[i] = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt_oh[i]) gnt_idx = IW'(i);
      end
      we_sel    = we[gnt_idx];
      addr_sel  = addr[gnt_idx*AW +: AW];
      width_sel = width[gnt_idx*3 +: 3];
      wdata_sel = wdata[gnt_idx*32 +: 32];
   end

   // Read buffer with the byte arriving this cycle already merged into its lane.
   always_comb begin
      rd_merge = buf_q;
      rd_merge[{cap_q[1:0], 3'b000} +: 8] = mem_din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q       <= ST_IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         nbeat_q    <= '0;
         wdata_q    <= '0;
         issue_q    <= '0;
         cap_q      <= '0;
         rd_pend_q  <= 1'b0;
         cap_pend_q <= 1'b0;
         stall_q    <= 1'b0;
         buf_q      <= '0;
         rdata_q    <= '0;
         done_q     <= '0;
         busy_q     <= '0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
      end else if (!rdy) begin
         stall_q <= 1'b1;
      end else begin
         stall_q <= 1'b0;
         done_q  <= '0;
         case (st_q)
            ST_IDLE: begin
               if (|req_eff) begin
                  we_q       <= we_sel;
                  addr_q     <= addr_sel;
                  nbeat_q    <= beats(width_sel);
                  wdata_q    <= wdata_sel;
                  busy_q     <= gnt_oh;
                  buf_q      <= '0;
                  cap_q      <= '0;
                  issue_q    <= 3'd1;
                  mem_a_q    <= addr_sel;
                  rd_pend_q  <= !we_sel;
                  cap_pend_q <= 1'b0;
                  mem_wr_q   <= we_sel;
                  mem_dout_q <= we_sel ? wdata_sel[7:0] : 8'h00;
                  st_q       <= ST_XFER;
               end
            end

            ST_XFER: begin
               if (we_q) begin
                  if (issue_q < nbeat_q) begin
                     mem_a_q    <= addr_q + AW'(issue_q);
                     mem_dout_q <= wdata_q[{issue_q[1:0], 3'b000} +: 8];
                     issue_q    <= issue_q + 3'd1;
                  end else begin
                     mem_wr_q   <= 1'b0;
                     mem_dout_q <= 8'h00;
                     busy_q     <= '0;
                     done_q     <= busy_q;
                     st_q       <= ST_DONE;
                  end
               end else if (stall_q) begin
                  // Bytes in flight during the stall were dropped: rewind to the
                  // first uncaptured address.
                  cap_pend_q <= 1'b0;
                  rd_pend_q  <= 1'b1;
                  mem_a_q    <= addr_q + AW'(cap_q);
                  issue_q    <= cap_q + 3'd1;
               end else begin
                  cap_pend_q <= rd_pend_q;
                  if (issue_q < nbeat_q) begin
                     mem_a_q   <= addr_q + AW'(issue_q);
                     issue_q   <= issue_q + 3'd1;
                     rd_pend_q <= 1'b1;
                  end else begin
                     rd_pend_q <= 1'b0;
                  end
                  if (cap_pend_q) begin
                     buf_q <= rd_merge;
                     cap_q <= cap_q + 3'd1;
                     if (cap_q + 3'd1 == nbeat_q) begin
                        rdata_q    <= rd_merge;
                        busy_q     <= '0;
                        done_q     <= busy_q;
                        rd_pend_q  <= 1'b0;
                        cap_pend_q <= 1'b0;
                        st_q       <= ST_DONE;
                     end
                  end
               end
            end

            ST_DONE: st_q <= ST_IDLE;

            default: st_q <= ST_IDLE;
         endcase
      end
   end

   assign rdata    = rdata_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign mem_a    = mem_a_q;
   assign mem_wr   = mem_wr_q & rdy;
   assign mem_dout = rdy ? mem_dout_q : 8'h00;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expected values are
// hand-computed per scenario, with a synchronous-read RAM model on the port.
module tb_mem_port_arbiter;

   localparam int NCH = 3;
   localparam int AW  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              rdy;
   logic [NCH-1:0]    req;
   logic [NCH-1:0]    we;
   logic [NCH*AW-1:0] addr;
   logic [NCH*3-1:0]  width;
   logic [NCH*32-1:0] wdata;
   logic [31:0]       rdata;
   logic [NCH-1:0]    done;
   logic [NCH-1:0]    busy;
   logic [7:0]        mem_din;
   logic [7:0]        mem_dout;
   logic [AW-1:0]     mem_a;
   logic              mem_wr;

   logic [7:0] ram [0:1023];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) mem_din <= ram[mem_a[9:0]];

   mem_port_arbiter #(
      .NCH (NCH),
      .AW  (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .req      (req),
      .we       (we),
      .addr     (addr),
      .width    (width),
      .wdata    (wdata),
      .rdata    (rdata),
      .done     (done),
      .busy     (busy),
      .mem_din  (mem_din),
      .mem_dout (mem_dout),
      .mem_a    (mem_a),
      .mem_wr   (mem_wr)
   );

   task automatic clear_inputs();
      req   = '0;
      we    = '0;
      addr  = '0;
      width = '0;
      wdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      rdy = 1'b1;
      clear_inputs();
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++; if (done !== 3'b000) begin n_errors++; $display("FAIL reset done: got %b want 000", done); end
      n_checks++; if (busy !== 3'b000) begin n_errors++; $display("FAIL reset busy: got %b want 000", busy); end
      n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset rdata: got %h want 0", rdata); end
      n_checks++; if (mem_a !== 32'h0) begin n_errors++; $display("FAIL reset mem_a: got %h want 0", mem_a); end
      n_checks++; if (mem_wr !== 1'b0) begin n_errors++; $display("FAIL reset mem_wr: got %b want 0", mem_wr); end
      n_checks++; if (mem_dout !== 8'h00) begin n_errors++; $display("FAIL reset mem_dout: got %h want 0", mem_dout); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 3'b000) begin n_errors++; $display("FAIL reset idle busy: got %b want 000", busy); end
   endtask

   task automatic test_word_read();
      logic [2:0]  exp_busy;
      logic [2:0]  exp_done;
      ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
      req[1] = 1'b1; we[1] = 1'b0; addr[1*AW +: AW] = 32'h100; width[1*3 +: 3] = 3'd2;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         exp_busy = (k <= 5) ? 3'b010 : 3'b000;
         exp_done = (k == 6) ? 3'b010 : 3'b000;
         if (k <= 4) begin
            n_checks++;
            if (mem_a !== 32'h100 + 32'(k - 1)) begin n_errors++; $display("FAIL word_read mem_a cyc %0d: got %h want %h", k, mem_a, 32'h100 + 32'(k - 1)); end
         end
         n_checks++; if (mem_wr !== 1'b0) begin n_errors++; $display("FAIL word_read mem_wr cyc %0d: got %b want 0", k, mem_wr); end
         n_checks++; if (busy !== exp_busy) begin n_errors++; $display("FAIL word_read busy cyc %0d: got %b want %b", k, busy, exp_busy); end
         n_checks++; if (done !== exp_done) begin n_errors++; $display("FAIL word_read done cyc %0d: got %b want %b", k, done, exp_done); end
      end
      n_checks++; if (rdata !== 32'h44332211) begin n_errors++; $display("FAIL word_read rdata: got %h want 44332211", rdata); end
      req[1] = 1'b0;
      @(negedge clk);
      n_checks++; if (done !== 3'b000) begin n_errors++; $display("FAIL word_read done after: got %b want 000", done); end
      n_checks++; if (rdata !== 32'h44332211) begin n_errors++; $display("FAIL word_read rdata hold: got %h want 44332211", rdata); end
   endtask

   task automatic test_half_write();
      logic [31:0] exp_a   [2];
      logic [7:0]  exp_d   [2];
      exp_a = '{32'h203, 32'h204};
      exp_d = '{8'hEF, 8'hBE};
      req[2] = 1'b1; we[2] = 1'b1; addr[2*AW +: AW] = 32'h203; width[2*3 +: 3] = 3'd1;
      wdata[2*32 +: 32] = 32'h0000BEEF;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         n_checks++; if (mem_wr !== 1'b1) begin n_errors++; $display("FAIL half_write mem_wr beat %0d: got %b want 1", k, mem_wr); end
         n_checks++; if (mem_a !== exp_a[k-1]) begin n_errors++; $display("FAIL half_write mem_a beat %0d: got %h want %h", k, mem_a, exp_a[k-1]); end
         n_checks++; if (mem_dout !== exp_d[k-1]) begin n_errors++; $display("FAIL half_write mem_dout beat %0d: got %h want %h", k, mem_dout, exp_d[k-1]); end
         n_checks++; if (busy !== 3'b100) begin n_errors++; $display("FAIL half_write busy beat %0d: got %b want 100", k, busy); end
      end
      @(negedge clk);
      n_checks++; if (done !== 3'b100) begin n_errors++; $display("FAIL half_write done: got %b want 100", done); end
      n_checks++; if (mem_wr !== 1'b0) begin n_errors++; $display("FAIL half_write mem_wr end: got %b want 0", mem_wr); end
      n_checks++; if (mem_dout !== 8'h00) begin n_errors++; $display("FAIL half_write mem_dout end: got %h want 0", mem_dout); end
      req[2] = 1'b0; we[2] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_arbitration();
      int exp_order [4];
      int n_exp;
      int n_done;
      int ch;
`ifdef MEMARB_RR_EN
      exp_order = '{0, 1, 2, 0};
      n_exp     = 4;
`else
      exp_order = '{0, 0, 0, 0};
      n_exp     = 3;
`endif
      n_done = 0;
      for (int c = 0; c < NCH; c++) begin
         ram[10'h300 + c] = 8'hA0 + 8'(c);
         addr[c*AW +: AW] = 32'h300 + 32'(c);
         width[c*3 +: 3]  = 3'd0;
         we[c]            = 1'b0;
      end
      req = 3'b111;
      for (int cyc = 0; cyc < 40 && n_done < n_exp; cyc++) begin
         @(negedge clk);
         n_checks++; if ($countones(busy) > 1) begin n_errors++; $display("FAIL arb busy onehot: got %b", busy); end
         if (done !== 3'b000) begin
            ch = -1;
            for (int i = 0; i < NCH; i++) if (done[i]) ch = i;
            n_checks++; if (!$onehot(done)) begin n_errors++; $display("FAIL arb done onehot: got %b", done); end
            n_checks++; if (ch != exp_order[n_done]) begin n_errors++; $display("FAIL arb order %0d: got ch %0d want ch %0d", n_done, ch, exp_order[n_done]); end
            n_checks++; if (rdata !== 32'h000000A0 + 32'(ch)) begin n_errors++; $display("FAIL arb rdata ch %0d: got %h want %h", ch, rdata, 32'h000000A0 + 32'(ch)); end
            n_done++;
            if (n_done == n_exp) req = '0;
         end
      end
      n_checks++; if (n_done != n_exp) begin n_errors++; $display("FAIL arb timeout: got %0d grants want %0d", n_done, n_exp); end
      req = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 3'b000) begin n_errors++; $display("FAIL arb busy after: got %b want 000", busy); end
   endtask

   task automatic test_stall();
      logic [31:0] exp_a [9];
      logic [2:0]  exp_done;
      exp_a = '{32'h140, 32'h141, 32'h142, 32'h142, 32'h142, 32'h142, 32'h141, 32'h142, 32'h143};
      ram[10'h140] = 8'h5A; ram[10'h141] = 8'h6B; ram[10'h142] = 8'h7C; ram[10'h143] = 8'h8D;
      clear_inputs();
      req[0] = 1'b1; addr[0 +: AW] = 32'h140; width[0 +: 3] = 3'd2;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         exp_done = (k == 11) ? 3'b001 : 3'b000;
         n_checks++; if (mem_wr !== 1'b0) begin n_errors++; $display("FAIL stall mem_wr cyc %0d: got %b want 0", k, mem_wr); end
         if (k <= 9) begin
            n_checks++;
            if (mem_a !== exp_a[k-1]) begin n_errors++; $display("FAIL stall mem_a cyc %0d: got %h want %h", k, mem_a, exp_a[k-1]); end
         end
         n_checks++; if (done !== exp_done) begin n_errors++; $display("FAIL stall done cyc %0d: got %b want %b", k, done, exp_done); end
         if (k == 3) rdy = 1'b0;
         if (k == 6) rdy = 1'b1;
      end
      n_checks++; if (rdata !== 32'h8D7C6B5A) begin n_errors++; $display("FAIL stall rdata: got %h want 8d7c6b5a", rdata); end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      req[0] = 1'b1; we[0] = 1'b1; addr[0 +: AW] = 32'h400; width[0 +: 3] = 3'd2;
      wdata[0 +: 32] = 32'hDEADBEEF;
      @(negedge clk);
      n_checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h400 || mem_dout !== 8'hEF) begin
         n_errors++; $display("FAIL rst_mid beat1: got wr %b a %h d %h want 1 400 ef", mem_wr, mem_a, mem_dout); end
      @(negedge clk);
      n_checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h401 || mem_dout !== 8'hBE) begin
         n_errors++; $display("FAIL rst_mid beat2: got wr %b a %h d %h want 1 401 be", mem_wr, mem_a, mem_dout); end
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      n_checks++; if (mem_wr !== 1'b0) begin n_errors++; $display("FAIL rst_mid mem_wr: got %b want 0", mem_wr); end
      n_checks++; if (mem_a !== 32'h0) begin n_errors++; $display("FAIL rst_mid mem_a: got %h want 0", mem_a); end
      n_checks++; if (mem_dout !== 8'h00) begin n_errors++; $display("FAIL rst_mid mem_dout: got %h want 0", mem_dout); end
      n_checks++; if (busy !== 3'b000 || done !== 3'b000) begin n_errors++; $display("FAIL rst_mid busy/done: got %b/%b want 000/000", busy, done); end
      n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL rst_mid rdata: got %h want 0", rdata); end
      rst = 1'b1;
      @(negedge clk);
      ram[10'h120] = 8'h77;
      req[2] = 1'b1; addr[2*AW +: AW] = 32'h120; width[2*3 +: 3] = 3'd0;
      @(negedge clk);
      n_checks++; if (mem_a !== 32'h120 || busy !== 3'b100) begin n_errors++; $display("FAIL rst_mid new grant: got a %h busy %b want 120 100", mem_a, busy); end
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (done !== 3'b100) begin n_errors++; $display("FAIL rst_mid new done: got %b want 100", done); end
      n_checks++; if (rdata !== 32'h00000077) begin n_errors++; $display("FAIL rst_mid new rdata: got %h want 77", rdata); end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_busy [9];
      logic [2:0] exp_done [9];
      exp_busy = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000};
      exp_done = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000};
      ram[10'h110] = 8'h5C;
      clear_inputs();
      req[1] = 1'b1; addr[1*AW +: AW] = 32'h110; width[1*3 +: 3] = 3'd0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         n_checks++; if (busy !== exp_busy[k-1]) begin n_errors++; $display("FAIL b2b busy cyc %0d: got %b want %b", k, busy, exp_busy[k-1]); end
         n_checks++; if (done !== exp_done[k-1]) begin n_errors++; $display("FAIL b2b done cyc %0d: got %b want %b", k, done, exp_done[k-1]); end
         if (k == 1 || k == 5) begin
            n_checks++;
            if (mem_a !== 32'h110) begin n_errors++; $display("FAIL b2b mem_a cyc %0d: got %h want 110", k, mem_a); end
         end
         if (k == 3) begin
            n_checks++;
            if (rdata !== 32'h5C) begin n_errors++; $display("FAIL b2b rdata 1: got %h want 5c", rdata); end
            ram[10'h110] = 8'hC5;
         end
         if (k == 7) begin
            n_checks++;
            if (rdata !== 32'hC5) begin n_errors++; $display("FAIL b2b rdata 2: got %h want c5", rdata); end
            req = '0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_half_write();
      test_arbitration();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
